// File: rtl/seq_det_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_det_sched: configurable serial pattern detector with run control |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_det_sched (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [3:0] cfg_pat,
   input  logic [1:0] cfg_len,
   input  logic       cfg_ovl,
   input  logic [7:0] cfg_target,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   input  logic       abort,
   input  logic       done_ack,
   output logic       det,
   output logic [7:0] count,
   output logic       done,
   output logic       busy
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0] state_q,  state_d;
   logic [3:0] pat_q,    pat_d;
   logic [1:0] len_q,    len_d;
   logic       ovl_q,    ovl_d;
   logic [7:0] target_q, target_d;
   logic [3:0] hist_q,   hist_d;
   logic [2:0] fill_q,   fill_d;
   logic [7:0] count_q,  count_d;
   logic       det_q,    det_d;

   logic       w_accept;
   logic [3:0] w_hist_n;
   logic [2:0] w_fill_n;
   logic [2:0] w_len_full;
   logic [3:0] w_mask;
   logic       w_match;
   logic [7:0] w_count_inc;

   // Fill saturates at 4 so it always tells how many history bits are valid.
   always_comb begin
      w_accept    = in_valid && (state_q == c_RUN);
      w_hist_n    = {hist_q[2:0], in_bit};
      w_fill_n    = (fill_q == 3'd4) ? 3'd4 : fill_q + 3'd1;
      w_len_full  = {1'b0, len_q} + 3'd1;
      w_count_inc = count_q + 8'd1;
      case (len_q)
         2'd0:    w_mask = 4'b0001;
         2'd1:    w_mask = 4'b0011;
         2'd2:    w_mask = 4'b0111;
         default: w_mask = 4'b1111;
      endcase
      w_match = w_accept && (w_fill_n >= w_len_full) &&
                (((w_hist_n ^ pat_q) & w_mask) == 4'b0000);
   end

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      len_d    = len_q;
      ovl_d    = ovl_q;
      target_d = target_q;
      hist_d   = hist_q;
      fill_d   = fill_q;
      count_d  = count_q;
      det_d    = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (cfg_valid) begin
               pat_d    = cfg_pat;
               len_d    = cfg_len;
               ovl_d    = cfg_ovl;
               target_d = cfg_target;
               count_d  = 8'd0;
               hist_d   = 4'd0;
               fill_d   = 3'd0;
               state_d  = c_RUN;
            end
         end
         c_RUN: begin
            // Abort takes priority: a bit offered alongside it is consumed and dropped.
            if (abort) begin
               state_d = c_IDLE;
            end else if (w_accept) begin
               hist_d = w_hist_n;
               fill_d = w_fill_n;
               if (w_match) begin
                  det_d   = 1'b1;
                  count_d = w_count_inc;
                  if (!ovl_q) begin
                     fill_d = 3'd0;
                  end
                  if ((target_q != 8'd0) && (w_count_inc == target_q)) begin
                     state_d = c_DONE;
                  end
               end
            end
         end
         c_DONE: begin
            if (abort || done_ack) begin
               state_d = c_IDLE;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= c_IDLE;
         pat_q    <= 4'd0;
         len_q    <= 2'd0;
         ovl_q    <= 1'b0;
         target_q <= 8'd0;
         hist_q   <= 4'd0;
         fill_q   <= 3'd0;
         count_q  <= 8'd0;
         det_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         len_q    <= len_d;
         ovl_q    <= ovl_d;
         target_q <= target_d;
         hist_q   <= hist_d;
         fill_q   <= fill_d;
         count_q  <= count_d;
         det_q    <= det_d;
      end
   end

   assign cfg_ready = (state_q == c_IDLE);
   assign in_ready  = (state_q == c_RUN);
   assign done      = (state_q == c_DONE);
   assign busy      = (state_q == c_RUN) || (state_q == c_DONE);
   assign det       = det_q;
   assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_det_sched: directed scenarios plus random run vs. bit model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_det_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [3:0] cfg_pat;
   logic [1:0] cfg_len;
   logic       cfg_ovl;
   logic [7:0] cfg_target;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       abort;
   logic       done_ack;
   logic       det;
   logic [7:0] count;
   logic       done;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_det_sched u_dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_pat    (cfg_pat),
      .cfg_len    (cfg_len),
      .cfg_ovl    (cfg_ovl),
      .cfg_target (cfg_target),
      .in_valid   (in_valid),
      .in_bit     (in_bit),
      .in_ready   (in_ready),
      .abort      (abort),
      .done_ack   (done_ack),
      .det        (det),
      .count      (count),
      .done       (done),
      .busy       (busy)
   );

   // Reference: a list of the bits received since the last restart; a match is
   // the last L list entries spelling the pattern, most recent = pat[0].
   localparam int c_M_IDLE = 0;
   localparam int c_M_RUN  = 1;
   localparam int c_M_DONE = 2;

   int         m_phase  = c_M_IDLE;
   bit         m_win[$];
   logic [3:0] m_pat    = '0;
   int         m_len    = 1;
   bit         m_ovl    = 1'b0;
   int         m_target = 0;
   int         m_count  = 0;
   bit         m_det    = 1'b0;

   task automatic model_edge();
      bit hit;
      if (!rst) begin
         m_phase = c_M_IDLE; m_win.delete(); m_pat = '0; m_len = 1;
         m_ovl = 1'b0; m_target = 0; m_count = 0; m_det = 1'b0;
         return;
      end
      m_det = 1'b0;
      if (m_phase == c_M_IDLE) begin
         if (cfg_valid) begin
            m_pat = cfg_pat; m_len = int'(cfg_len) + 1; m_ovl = cfg_ovl;
            m_target = int'(cfg_target); m_count = 0; m_win.delete();
            m_phase = c_M_RUN;
         end
      end else if (m_phase == c_M_RUN) begin
         if (abort) begin
            m_phase = c_M_IDLE;
         end else if (in_valid) begin
            m_win.push_back(in_bit);
            if (m_win.size() > 4) void'(m_win.pop_front());
            hit = (m_win.size() >= m_len);
            for (int k = 0; k < m_len; k++)
               if (hit && (m_win[m_win.size() - 1 - k] != m_pat[k])) hit = 1'b0;
            if (hit) begin
               m_det = 1'b1;
               m_count = (m_count + 1) % 256;
               if (!m_ovl) m_win.delete();
               if (m_target != 0 && m_count == m_target) m_phase = c_M_DONE;
            end
         end
      end else begin
         if (abort || done_ack) m_phase = c_M_IDLE;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic configure(input logic [3:0] p, input logic [1:0] l,
                            input logic o, input logic [7:0] t);
      cfg_valid = 1'b1; cfg_pat = p; cfg_len = l; cfg_ovl = o; cfg_target = t;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic send_bit(input logic b, input logic ab);
      in_valid = 1'b1; in_bit = b; abort = ab;
      tick();
      in_valid = 1'b0; abort = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; abort = 1'b1; done_ack = 1'b1; cfg_valid = 1'b1;
      tick();
      tick();
      abort = 1'b0; done_ack = 1'b0; cfg_valid = 1'b0;
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if ({det, done, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags det/done/busy got=%b exp=000", {det, done, busy}); end
      checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      rst = 1'b1;
      tick();
      checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_release cfg_ready=%b busy=%b exp 1/0", cfg_ready, busy); end
   endtask

   // Stream 1011011 1011: non-overlap hits at bits 4 and 11, overlap adds bit 7.
   task automatic run_stream(input logic ovl, input logic [7:0] tgt, input string name);
      logic [10:0] s;
      logic        exp_det;
      s = 11'b10110111011;
      configure(4'b1011, 2'd3, ovl, tgt);
      for (int i = 1; i <= 11; i++) begin
         send_bit(s[11 - i], 1'b0);
         exp_det = (i == 4) || (i == 11) || (ovl && i == 7);
         checks++; if (det !== exp_det) begin failures++; $display("FAIL %s_det bit=%0d got=%b exp=%b", name, i, det, exp_det); end
         if (i == 10) begin
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_early_done got=%b exp=0", name, done); end
         end
      end
      checks++; if (count !== tgt) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", name, count, tgt); end
      checks++; if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL %s_end done=%b in_ready=%b busy=%b exp 1/0/1", name, done, in_ready, busy); end
   endtask

   task automatic test_nonovl();
      run_stream(1'b0, 8'd2, "nonovl");
   endtask

   task automatic test_done_ack();
      done_ack = 1'b1;
      tick();
      done_ack = 1'b0;
      checks++; if (cfg_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ack_idle cfg_ready=%b done=%b exp 1/0", cfg_ready, done); end
      checks++; if (count !== 8'd2) begin failures++; $display("FAIL ack_count_held got=%0d exp=2", count); end
      configure(4'b0110, 2'd2, 1'b0, 8'd0);
      checks++; if (count !== 8'd0 || busy !== 1'b1) begin failures++; $display("FAIL newcfg count=%0d busy=%b exp 0/1", count, busy); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_ovl();
      run_stream(1'b1, 8'd3, "ovl");
      done_ack = 1'b1; tick(); done_ack = 1'b0;
   endtask

   task automatic test_len1_gaps();
      logic [3:0] s;
      int         pulses;
      s = 4'b1101;
      pulses = 0;
      configure(4'b1101, 2'd0, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         send_bit(s[3 - i], 1'b0);
         pulses += int'(det);
         checks++; if (det !== s[3 - i]) begin failures++; $display("FAIL len1_det idx=%0d got=%b exp=%b", i, det, s[3 - i]); end
         tick();
         checks++; if (det !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL len1_gap idx=%0d det=%b busy=%b exp 0/1", i, det, busy); end
      end
      checks++; if (count !== 8'd3 || pulses != 3) begin failures++; $display("FAIL len1_count count=%0d pulses=%0d exp 3/3", count, pulses); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_abort_match();
      configure(4'b1011, 2'd3, 1'b0, 8'd0);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      checks++; if (det !== 1'b0) begin failures++; $display("FAIL abort_det got=%b exp=0", det); end
      checks++; if (count !== 8'd1) begin failures++; $display("FAIL abort_count got=%0d exp=1", count); end
      checks++; if (cfg_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL abort_idle cfg_ready=%b busy=%b exp 1/0", cfg_ready, busy); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++; if (cfg_ready !== 1'b1 || count !== 8'd1) begin failures++; $display("FAIL abort_in_idle cfg_ready=%b count=%0d exp 1/1", cfg_ready, count); end
   endtask

   task automatic test_rst_mid();
      configure(4'b1011, 2'd3, 1'b0, 8'd0);
      send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
      rst = 1'b0; tick(); rst = 1'b1;
      checks++; if ({det, done, busy, in_ready} !== 4'b0000 || count !== 8'd0) begin failures++; $display("FAIL rstmid_outputs det/done/busy/in_ready=%b count=%0d exp 0000/0", {det, done, busy, in_ready}, count); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_cfg_ready got=%b exp=1", cfg_ready); end
      configure(4'b1011, 2'd3, 1'b0, 8'd0);
      send_bit(1'b1, 1'b0);
      checks++; if (det !== 1'b0) begin failures++; $display("FAIL rstmid_stale_history det=%b exp=0", det); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_wrap();
      configure(4'b0001, 2'd0, 1'b0, 8'd0);
      for (int i = 1; i <= 256; i++) begin
         send_bit(1'b1, 1'b0);
         if (i == 255) begin
            checks++; if (count !== 8'd255) begin failures++; $display("FAIL wrap_255 got=%0d exp=255", count); end
         end
      end
      checks++; if (count !== 8'd0 || det !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL wrap_0 count=%0d det=%b busy=%b exp 0/1/1", count, det, busy); end
      abort = 1'b1; tick(); abort = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         rst        = ($urandom_range(0, 249) != 0);
         cfg_valid  = ($urandom_range(0, 9) < 3);
         cfg_pat    = 4'($urandom);
         cfg_len    = 2'($urandom);
         cfg_ovl    = 1'($urandom);
         cfg_target = 8'($urandom_range(0, 6));
         in_valid   = ($urandom_range(0, 3) != 0);
         in_bit     = 1'($urandom);
         abort      = ($urandom_range(0, 39) == 0);
         done_ack   = ($urandom_range(0, 3) == 0);
         tick();
         checks++; if (det !== m_det) begin failures++; $display("FAIL rnd_det cyc=%0d got=%b exp=%b", c, det, m_det); end
         checks++; if (count !== 8'(m_count)) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, m_count); end
         checks++; if (cfg_ready !== (m_phase == c_M_IDLE)) begin failures++; $display("FAIL rnd_cfg_ready cyc=%0d got=%b", c, cfg_ready); end
         checks++; if (in_ready !== (m_phase == c_M_RUN)) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b", c, in_ready); end
         checks++; if (done !== (m_phase == c_M_DONE)) begin failures++; $display("FAIL rnd_done cyc=%0d got=%b", c, done); end
         checks++; if (busy !== (m_phase != c_M_IDLE)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b", c, busy); end
      end
      rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; abort = 1'b0; done_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cfg_valid = 1'b0; cfg_pat = '0; cfg_len = '0; cfg_ovl = 1'b0;
      cfg_target = '0; in_valid = 1'b0; in_bit = 1'b0; abort = 1'b0; done_ack = 1'b0;
      @(negedge clk);
      test_reset();
      test_nonovl();
      test_done_ack();
      test_ovl();
      test_len1_gaps();
      test_abort_match();
      test_rst_mid();
      test_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
